// File: rtl/tick_period_meter.sv
// ============================================================================
// Module   : tick_period_meter
// Function : Measures clk-cycle spacing between rising edges of a tick stream
//            and presents each result through a valid/ready holding register.
//            Define TICK_METER_AVG4_EN to report the mean of 4 periods instead.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_period_meter #(
  parameter int unsigned       WIDTH      = 32,
  // All-ones is 2**WIDTH-1, the largest count that cannot wrap.
  parameter logic [WIDTH-1:0]  MAX_PERIOD = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  input  logic             period_ready,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] c_CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_tick_q;
  logic             w_rise;
  logic             w_meas_rise;
  logic             w_tmo;
  logic             w_load;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_overrun;
  logic             r_timeout;

  assign w_rise = tick_in & ~r_tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tick_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tick_q <= tick_in;
    end
  end

  // Dropping enable wins over both a rise and a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_meas_rise = 1'b0;
    w_tmo       = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ARM;
        end
        S_ARM: begin
          if (w_rise) begin
            w_cnt_nxt   = c_CNT_ONE;
            w_state_nxt = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_meas_rise = 1'b1;
            w_cnt_nxt   = c_CNT_ONE;
          end else if (r_cnt == MAX_PERIOD) begin
            w_tmo       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_ARM;
          end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef TICK_METER_AVG4_EN
  logic [WIDTH+1:0] r_sum;
  logic [1:0]       r_phase;
  logic [WIDTH+1:0] w_sum_add;

  // Two guard bits hold four full-scale periods without overflow.
  assign w_sum_add = r_sum + {2'b00, r_cnt};
  assign w_load    = w_meas_rise && (r_phase == 2'd3);
  assign w_result  = w_sum_add[WIDTH+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum   <= '0;
      r_phase <= 2'd0;
    end else if (!enable || w_tmo) begin
      r_sum   <= '0;
      r_phase <= 2'd0;
    end else if (w_meas_rise) begin
      if (r_phase == 2'd3) begin
        r_sum   <= '0;
        r_phase <= 2'd0;
      end else begin
        r_sum   <= w_sum_add;
        r_phase <= r_phase + 2'd1;
      end
    end
  end
`else
  assign w_load   = w_meas_rise;
  assign w_result = r_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (w_load) begin
        r_period <= w_result;
        r_valid  <= 1'b1;
        if (r_valid && !period_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (period_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign overrun      = r_overrun;
  assign timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_tick_period_meter.sv
// ============================================================================
// Module   : tb_tick_period_meter
// Function : Directed self-checking bench for tick_period_meter (MAX_PERIOD=10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_period_meter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        tick_in;
  logic        period_ready;
  logic [31:0] period_out;
  logic        period_valid;
  logic        overrun;
  logic        timeout;

  int          n_cmp;
  int          n_err;
  int          valid_cycles;
  logic [31:0] res_q[$];

  tick_period_meter #(
    .WIDTH      (32),
    .MAX_PERIOD (32'd10)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick_in      (tick_in),
    .period_ready (period_ready),
    .period_out   (period_out),
    .period_valid (period_valid),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted results and valid occupancy, sampled mid-cycle.
  always @(negedge clk) begin
    if (period_valid) valid_cycles++;
    if (period_valid && period_ready) res_q.push_back(period_out);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  // One rise followed by gap-1 further cycles, so the next rise lands gap cycles later.
  task automatic rise_gap(input int gap, input bit held);
    step(1'b1);
    for (int i = 1; i < gap; i++) begin
      step(held && (i < gap - 1));
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    step(1'b0);
    step(1'b0);
    enable = 1'b1;
    step(1'b0);
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (res_q.size() > i) ? res_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    valid_cycles = 0;
    reset = 1'b1;
    enable = 1'b0;
    tick_in = 1'b0;
    period_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0);
    check_eq("rst_period_out", period_out, 32'd0);
    check_eq("rst_valid", {31'd0, period_valid}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);

    // Steady 5-cycle ticks, consumer always ready.
    period_ready = 1'b1;
    rearm();
    res_q.delete();
    valid_cycles = 0;
    rise_gap(5, 1'b0);
    check_eq("p5_first_rise_no_result", res_q.size(), 32'd0);
    repeat (3) rise_gap(5, 1'b0);
    rise_gap(5, 1'b0);
    check_eq("p5_count", res_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("p5_value", q_at(i), 32'd5);
    check_eq("p5_valid_cycles", valid_cycles, 32'd4);

    // Irregular spacing, single-cycle and held-high ticks.
    for (int h = 0; h < 2; h++) begin
      rearm();
      res_q.delete();
      rise_gap(3, h[0]);
      rise_gap(7, h[0]);
      rise_gap(2, h[0]);
      rise_gap(4, h[0]);
      check_eq("seq_count", res_q.size(), 32'd3);
      check_eq("seq_r0", q_at(0), 32'd3);
      check_eq("seq_r1", q_at(1), 32'd7);
      check_eq("seq_r2", q_at(2), 32'd2);
    end

    // Back-pressure: second result overwrites the first.
    period_ready = 1'b0;
    rearm();
    rise_gap(4, 1'b0);
    step(1'b1);
    check_eq("bp_first_out", period_out, 32'd4);
    check_eq("bp_first_valid", {31'd0, period_valid}, 32'd1);
    check_eq("bp_first_overrun", {31'd0, overrun}, 32'd0);
    repeat (5) step(1'b0);
    step(1'b1);
    check_eq("bp_second_out", period_out, 32'd6);
    check_eq("bp_second_valid", {31'd0, period_valid}, 32'd1);
    check_eq("bp_overrun", {31'd0, overrun}, 32'd1);
    period_ready = 1'b1;
    step(1'b0);
    check_eq("bp_accept_valid", {31'd0, period_valid}, 32'd0);
    check_eq("bp_hold_out", period_out, 32'd6);
    check_eq("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Timeout after 10 silent cycles, then back to ARM.
    rearm();
    res_q.delete();
    step(1'b1);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0);
      check_eq($sformatf("tmo_k%0d", k), {31'd0, timeout}, (k == 10) ? 32'd1 : 32'd0);
    end
    check_eq("tmo_no_result", res_q.size(), 32'd0);
    rise_gap(4, 1'b0);
    check_eq("tmo_rearm_no_result", res_q.size(), 32'd0);
    step(1'b1);
    check_eq("tmo_next_out", period_out, 32'd4);
    check_eq("tmo_next_valid", {31'd0, period_valid}, 32'd1);

    // Asynchronous reset in the middle of a period.
    period_ready = 1'b0;
    rearm();
    rise_gap(4, 1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check_eq("ar_pre_valid", {31'd0, period_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_period_out", period_out, 32'd0);
    check_eq("ar_valid", {31'd0, period_valid}, 32'd0);
    check_eq("ar_overrun", {31'd0, overrun}, 32'd0);
    check_eq("ar_timeout", {31'd0, timeout}, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    period_ready = 1'b1;
    res_q.delete();
    step(1'b0);
    rise_gap(8, 1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check_eq("ar_after_count", res_q.size(), 32'd1);
    check_eq("ar_after_value", q_at(0), 32'd8);

`ifdef TICK_METER_AVG4_EN
    rearm();
    res_q.delete();
    rise_gap(4, 1'b0);
    rise_gap(5, 1'b0);
    rise_gap(6, 1'b0);
    check_eq("avg_none_yet", res_q.size(), 32'd0);
    rise_gap(8, 1'b0);
    step(1'b1);
    step(1'b0);
    check_eq("avg_count", res_q.size(), 32'd1);
    check_eq("avg_value", q_at(0), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
